// File: rtl/ex_stage.sv
// Execute stage of the IITB-RISC-23 pipeline.
// Holds the ALU, the predication logic, the architectural condition-code
// register (C, Z) and branch/jump resolution. Results are registered into
// the EX/MEM register, which supports stall and flush.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [15:0] store_data,
    input  logic [15:0] imm_eff,
    input  logic [15:0] pc,
    input  logic [15:0] pc2,
    input  logic [2:0]  alu_op,
    input  logic        invert_b,
    input  logic        use_carry_in,
    input  logic        pred_en,
    input  logic [1:0]  pred_cz,
    input  logic        pred_is_w,
    input  logic        rf_we_cand,
    input  logic [2:0]  rf_waddr,
    input  logic [1:0]  wb_sel,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        ccr_we_C_cand,
    input  logic        ccr_we_Z_cand,
    input  logic        is_branch,
    input  logic [1:0]  br_type,
    input  logic        is_jump,
    input  logic        is_link,
    input  logic        jump_is_reg,
    input  logic        ld_z_we,
    input  logic        ld_z,
    output logic        redirect_valid,
    output logic [15:0] redirect_pc,
    output logic        c_flag,
    output logic        z_flag,
    output logic [15:0] mem_alu_result,
    output logic [15:0] mem_store_data,
    output logic [15:0] mem_pc2,
    output logic        mem_rf_we,
    output logic [2:0]  mem_rf_waddr,
    output logic [1:0]  mem_wb_sel,
    output logic        mem_rd_o,
    output logic        mem_wr_o
);

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_NAND   = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_PASS_B = 3'd3;

    logic        ze_s;
    logic        pred_s;
    logic [15:0] b_eff_s;
    logic        cin_s;
    logic [16:0] sum_s;
    logic [15:0] result_s;
    logic        carry_s;
    logic        zero_s;
    logic        br_cond_s;
    logic [15:0] br_tgt_s;
    logic [15:0] jmp_tgt_s;

    // Effective Z (forwarding the older load's zero flag) and the predicate.
    always_comb begin
        ze_s   = z_flag;
        pred_s = 1'b1;
        if (ld_z_we) begin
            ze_s = ld_z;
        end else begin
            ze_s = z_flag;
        end
        if (!pred_en || pred_is_w) begin
            pred_s = 1'b1;
        end else begin
            case (pred_cz)
                2'b10:   pred_s = c_flag;
                2'b01:   pred_s = ze_s;
                default: pred_s = 1'b1;
            endcase
        end
    end

    // ALU datapath; opcodes that do not produce a carry leave C as it is.
    always_comb begin
        b_eff_s  = invert_b ? ~opB : opB;
        cin_s    = use_carry_in ? c_flag : 1'b0;
        sum_s    = 17'd0;
        result_s = 16'h0000;
        carry_s  = c_flag;
        case (alu_op)
            ALU_ADD: begin
                sum_s    = {1'b0, opA} + {1'b0, b_eff_s} + {16'd0, cin_s};
                result_s = sum_s[15:0];
                carry_s  = sum_s[16];
            end
            ALU_NAND: begin
                result_s = ~(opA & b_eff_s);
            end
            ALU_SUB: begin
                sum_s    = {1'b0, opA} + {1'b0, ~opB} + 17'd1;
                result_s = sum_s[15:0];
                carry_s  = sum_s[16];
            end
            ALU_PASS_B: begin
                result_s = opB;
            end
            default: begin
                result_s = 16'h0000;
            end
        endcase
        zero_s = (result_s == 16'h0000);
    end

    // Branch condition (unsigned compares) and branch/jump targets.
    always_comb begin
        case (br_type)
            2'b00:   br_cond_s = (opA == opB);
            2'b01:   br_cond_s = (opA < opB);
            2'b10:   br_cond_s = (opA <= opB);
            default: br_cond_s = 1'b0;
        endcase
        br_tgt_s = pc + imm_eff;
        if (jump_is_reg) begin
            if (is_link) begin
                jmp_tgt_s = opB;
            end else begin
                jmp_tgt_s = opA + imm_eff;
            end
        end else begin
            jmp_tgt_s = br_tgt_s;
        end
    end

    // Redirect to fetch; control flow ignores predication but a stalled EX
    // must not redirect because the instruction will be re-presented.
    always_comb begin
        redirect_valid = !stall && ((is_branch && br_cond_s) || is_jump);
        if (is_jump) begin
            redirect_pc = jmp_tgt_s;
        end else begin
            redirect_pc = br_tgt_s;
        end
    end

    // Condition-code register; EX writes win over the load-zero write
    // because EX holds the younger instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else if (!stall && !flush) begin
            if (ccr_we_C_cand && pred_s) begin
                c_flag <= carry_s;
            end
            if (ccr_we_Z_cand && pred_s) begin
                z_flag <= zero_s;
            end else if (ld_z_we) begin
                z_flag <= ld_z;
            end
        end
    end

    // EX/MEM pipeline register: stall holds, flush inserts a bubble, and a
    // failed predicate turns the instruction into a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result <= 16'h0000;
            mem_store_data <= 16'h0000;
            mem_pc2        <= 16'h0000;
            mem_rf_we      <= 1'b0;
            mem_rf_waddr   <= 3'd0;
            mem_wb_sel     <= 2'd0;
            mem_rd_o       <= 1'b0;
            mem_wr_o       <= 1'b0;
        end else if (stall) begin
            mem_alu_result <= mem_alu_result;
        end else if (flush) begin
            mem_alu_result <= 16'h0000;
            mem_store_data <= 16'h0000;
            mem_pc2        <= 16'h0000;
            mem_rf_we      <= 1'b0;
            mem_rf_waddr   <= 3'd0;
            mem_wb_sel     <= 2'd0;
            mem_rd_o       <= 1'b0;
            mem_wr_o       <= 1'b0;
        end else begin
            mem_alu_result <= result_s;
            mem_store_data <= store_data;
            mem_pc2        <= pc2;
            mem_rf_we      <= rf_we_cand && pred_s;
            mem_rf_waddr   <= rf_waddr;
            mem_wb_sel     <= wb_sel;
            mem_rd_o       <= mem_rd && pred_s;
            mem_wr_o       <= mem_wr && pred_s;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed vectors push hand-computed
// expectations; a forked monitor pops one entry after each clock edge.
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic [15:0] opA, opB, store_data, imm_eff, pc, pc2;
    logic [2:0]  alu_op;
    logic        invert_b, use_carry_in, pred_en;
    logic [1:0]  pred_cz;
    logic        pred_is_w, rf_we_cand;
    logic [2:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic        mem_rd, mem_wr, ccr_we_C_cand, ccr_we_Z_cand;
    logic        is_branch;
    logic [1:0]  br_type;
    logic        is_jump, is_link, jump_is_reg, ld_z_we, ld_z;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        c_flag, z_flag;
    logic [15:0] mem_alu_result, mem_store_data, mem_pc2;
    logic        mem_rf_we;
    logic [2:0]  mem_rf_waddr;
    logic [1:0]  mem_wb_sel;
    logic        mem_rd_o, mem_wr_o;

    typedef struct packed {
        logic        rv;
        logic [15:0] rpc;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] p2;
        logic        we;
        logic [2:0]  wa;
        logic [1:0]  ws;
        logic        rd;
        logic        wr;
        logic        c;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .opA(opA), .opB(opB), .store_data(store_data), .imm_eff(imm_eff),
        .pc(pc), .pc2(pc2), .alu_op(alu_op), .invert_b(invert_b),
        .use_carry_in(use_carry_in), .pred_en(pred_en), .pred_cz(pred_cz),
        .pred_is_w(pred_is_w), .rf_we_cand(rf_we_cand), .rf_waddr(rf_waddr),
        .wb_sel(wb_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ccr_we_C_cand(ccr_we_C_cand), .ccr_we_Z_cand(ccr_we_Z_cand),
        .is_branch(is_branch), .br_type(br_type), .is_jump(is_jump),
        .is_link(is_link), .jump_is_reg(jump_is_reg), .ld_z_we(ld_z_we),
        .ld_z(ld_z), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .c_flag(c_flag), .z_flag(z_flag), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_pc2(mem_pc2),
        .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .mem_wb_sel(mem_wb_sel), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic compare(input exp_t e);
        chk1("redirect_valid", redirect_valid, e.rv);
        if (e.rv) chk16("redirect_pc", redirect_pc, e.rpc);
        chk16("mem_alu_result", mem_alu_result, e.alu);
        chk16("mem_store_data", mem_store_data, e.sd);
        chk16("mem_pc2", mem_pc2, e.p2);
        chk1("mem_rf_we", mem_rf_we, e.we);
        chk16("mem_rf_waddr", {13'd0, mem_rf_waddr}, {13'd0, e.wa});
        chk16("mem_wb_sel", {14'd0, mem_wb_sel}, {14'd0, e.ws});
        chk1("mem_rd_o", mem_rd_o, e.rd);
        chk1("mem_wr_o", mem_wr_o, e.wr);
        chk1("c_flag", c_flag, e.c);
        chk1("z_flag", z_flag, e.z);
    endtask

    task automatic chk_all_zero(input string tag);
        chk16({tag, "_alu"}, mem_alu_result, 16'h0000);
        chk16({tag, "_sd"}, mem_store_data, 16'h0000);
        chk16({tag, "_pc2"}, mem_pc2, 16'h0000);
        chk1({tag, "_we"}, mem_rf_we, 1'b0);
        chk16({tag, "_wa"}, {13'd0, mem_rf_waddr}, 16'h0000);
        chk16({tag, "_ws"}, {14'd0, mem_wb_sel}, 16'h0000);
        chk1({tag, "_rd"}, mem_rd_o, 1'b0);
        chk1({tag, "_wr"}, mem_wr_o, 1'b0);
        chk1({tag, "_c"}, c_flag, 1'b0);
        chk1({tag, "_z"}, z_flag, 1'b0);
    endtask

    task automatic push(input logic rv, input logic [15:0] rpc, input logic [15:0] alu,
                        input logic [15:0] sd, input logic [15:0] p2, input logic we,
                        input logic [2:0] wa, input logic [1:0] ws, input logic rd,
                        input logic wr, input logic c, input logic z);
        exp_t e;
        e = '{rv, rpc, alu, sd, p2, we, wa, ws, rd, wr, c, z};
        sb_q.push_back(e);
    endtask

    task automatic clr();
        stall = 1'b0; flush = 1'b0;
        opA = 16'h0000; opB = 16'h0000; store_data = 16'h0000; imm_eff = 16'h0000;
        pc = 16'h0000; pc2 = 16'h0000; alu_op = 3'd0; invert_b = 1'b0;
        use_carry_in = 1'b0; pred_en = 1'b0; pred_cz = 2'b00; pred_is_w = 1'b0;
        rf_we_cand = 1'b0; rf_waddr = 3'd0; wb_sel = 2'd0; mem_rd = 1'b0;
        mem_wr = 1'b0; ccr_we_C_cand = 1'b0; ccr_we_Z_cand = 1'b0;
        is_branch = 1'b0; br_type = 2'b00; is_jump = 1'b0; is_link = 1'b0;
        jump_is_reg = 1'b0; ld_z_we = 1'b0; ld_z = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic step();
        @(negedge clk);
        clr();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr();

        fork
            forever begin
                @(posedge clk);
                #1;
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    compare(mon_e);
                end
            end
        join_none

        #3;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD FFFF+0001 -> 0000, C=1 Z=1
        step(); opA = 16'hFFFF; opB = 16'h0001; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        rf_we_cand = 1'b1; rf_waddr = 3'd3; store_data = 16'hAAAA; pc2 = 16'h0002;
        push(1'b0, 16'h0000, 16'h0000, 16'hAAAA, 16'h0002, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // SUB 0001-0002 -> FFFF, no carry
        step(); alu_op = 3'd2; opA = 16'h0001; opB = 16'h0002; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        rf_we_cand = 1'b1; rf_waddr = 3'd1; mem_rd = 1'b1; wb_sel = 2'd1;
        push(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        // predicated on C=0: no writes, CCR unchanged
        step(); pred_en = 1'b1; pred_cz = 2'b10; opA = 16'hFFFF; opB = 16'h0001;
        ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1; rf_we_cand = 1'b1; rf_waddr = 3'd2;
        mem_wr = 1'b1; mem_rd = 1'b1;
        push(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // predicate on forwarded load Z; Z written from load
        step(); pred_en = 1'b1; pred_cz = 2'b01; ld_z_we = 1'b1; ld_z = 1'b1;
        opA = 16'h0002; opB = 16'h0003; rf_we_cand = 1'b1; rf_waddr = 3'd5;
        push(1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // same with EX Z write: EX wins, Z=0
        step(); pred_en = 1'b1; pred_cz = 2'b01; ld_z_we = 1'b1; ld_z = 1'b1; ccr_we_Z_cand = 1'b1;
        opA = 16'h0002; opB = 16'h0003; rf_we_cand = 1'b1; rf_waddr = 3'd5;
        push(1'b0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b1, 3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // NAND with inverted B: ~(F0F0 & 00FF) = FF0F
        step(); alu_op = 3'd1; invert_b = 1'b1; opA = 16'hF0F0; opB = 16'hFF00;
        ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'hFF0F, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // ADD 8000+8000 -> 0000, C=1 Z=1
        step(); opA = 16'h8000; opB = 16'h8000; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // ADD with carry-in C=1: 1+1+1 = 3
        step(); use_carry_in = 1'b1; opA = 16'h0001; opB = 16'h0001;
        ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // ADD with inverted B: 5 + FFFE = 1_0003
        step(); invert_b = 1'b1; opA = 16'h0005; opB = 16'h0001; ccr_we_C_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // PASS_B: C unchanged
        step(); alu_op = 3'd3; opA = 16'h5555; opB = 16'h1234; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        // reserved op -> 0, Z=1
        step(); alu_op = 3'd5; opA = 16'h0001; opB = 16'h0002; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // BLE taken
        step(); is_branch = 1'b1; br_type = 2'b10; pc = 16'h0010; imm_eff = 16'h0004;
        opA = 16'h0007; opB = 16'h0007;
        push(1'b1, 16'h0014, 16'h000E, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // BLE not taken
        step(); is_branch = 1'b1; br_type = 2'b10; pc = 16'h0010; imm_eff = 16'h0004;
        opA = 16'h0008; opB = 16'h0007;
        push(1'b0, 16'h0000, 16'h000F, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // BLT taken, target wraps
        step(); is_branch = 1'b1; br_type = 2'b01; pc = 16'h0100; imm_eff = 16'hFFFC;
        opA = 16'h0003; opB = 16'h0007;
        push(1'b1, 16'h00FC, 16'h000A, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // BEQ taken
        step(); is_branch = 1'b1; br_type = 2'b00; pc = 16'h0020; imm_eff = 16'h0002;
        opA = 16'h0009; opB = 16'h0009;
        push(1'b1, 16'h0022, 16'h0012, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // br_type 11 never taken
        step(); is_branch = 1'b1; br_type = 2'b11; opA = 16'h0009; opB = 16'h0009;
        push(1'b0, 16'h0000, 16'h0012, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // JLR
        step(); is_jump = 1'b1; jump_is_reg = 1'b1; is_link = 1'b1; opA = 16'h0100; opB = 16'h1234;
        imm_eff = 16'h0010; pc = 16'h0010; pc2 = 16'h0022; alu_op = 3'd3;
        rf_we_cand = 1'b1; rf_waddr = 3'd7; wb_sel = 2'd2;
        push(1'b1, 16'h1234, 16'h1234, 16'h0000, 16'h0022, 1'b1, 3'd7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        // same JLR stalled, with CCR and load-Z writes pending: everything held
        step(); stall = 1'b1; is_jump = 1'b1; jump_is_reg = 1'b1; is_link = 1'b1; opA = 16'h0100;
        opB = 16'h1234; imm_eff = 16'h0010; pc = 16'h0010; pc2 = 16'h0055; alu_op = 3'd3;
        rf_we_cand = 1'b1; rf_waddr = 3'd7; wb_sel = 2'd2; ccr_we_Z_cand = 1'b1;
        ld_z_we = 1'b1; ld_z = 1'b0;
        push(1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0022, 1'b1, 3'd7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        // JRI
        step(); is_jump = 1'b1; jump_is_reg = 1'b1; opA = 16'h0100; opB = 16'h1234;
        imm_eff = 16'h0010; pc = 16'h0010; pc2 = 16'h0022; alu_op = 3'd3;
        rf_we_cand = 1'b1; rf_waddr = 3'd7; wb_sel = 2'd2;
        push(1'b1, 16'h0110, 16'h1234, 16'h0000, 16'h0022, 1'b1, 3'd7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        // JAL
        step(); is_jump = 1'b1; is_link = 1'b1; opA = 16'h0100; opB = 16'h1234;
        imm_eff = 16'h0010; pc = 16'h0010; pc2 = 16'h0012; alu_op = 3'd3;
        rf_we_cand = 1'b1; rf_waddr = 3'd7; wb_sel = 2'd2;
        push(1'b1, 16'h0020, 16'h1234, 16'h0000, 16'h0012, 1'b1, 3'd7, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        // flush: bubble, C not cleared by the flushed SUB
        step(); flush = 1'b1; alu_op = 3'd2; opA = 16'h0001; opB = 16'h0002;
        ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1; rf_we_cand = 1'b1; rf_waddr = 3'd4;
        mem_rd = 1'b1; store_data = 16'h5A5A; pc2 = 16'h0044; wb_sel = 2'd1;
        push(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        // normal load of nonzero state before a mid-stream reset
        step(); opA = 16'h0001; opB = 16'h0001; rf_we_cand = 1'b1; rf_waddr = 3'd6;
        store_data = 16'h1111; pc2 = 16'h0033; ccr_we_C_cand = 1'b1; ccr_we_Z_cand = 1'b1;
        push(1'b0, 16'h0000, 16'h0002, 16'h1111, 16'h0033, 1'b1, 3'd6, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // mid-stream asynchronous reset clears without a clock edge
        @(negedge clk);
        store_data = 16'h2222;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        clr(); is_branch = 1'b1; br_type = 2'b00; pc = 16'h0030; imm_eff = 16'h0006;
        opA = 16'h0004; opB = 16'h0004;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("redirect_after_release", redirect_valid, 1'b1);
        push(1'b1, 16'h0036, 16'h0008, 16'h0000, 16'h0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
